mux_n_1_stream: RTL and testbench

//  N-channel, DW-bit stream multiplexer with valid/ready handshakes and one

---
 rtl/mux_n_1_stream.sv | 104 ++++++++++
 tb/tb_mux_n_1_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_stream.sv
// rtl/mux_n_1_stream.sv - N:1 valid/ready stream mux with fixed or round-robin grant; optional counter via MUX_N_1_STREAM_CNT_EN
module mux_n_1_stream #(
    parameter int DW    = 4,
    parameter int CH    = 4,
    parameter int SEL_W = $clog2(CH),
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CH*DW-1:0]  i_data,
    input  logic [CH-1:0]     i_valid,
    output logic [CH-1:0]     o_ready,
    input  logic              i_mode,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DW-1:0]     o_data,
    output logic [SEL_W-1:0]  o_ch,
    output logic              o_valid,
    input  logic              i_ready
`ifdef MUX_N_1_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_xfer_cnt
`endif
);

    if (CH < 2 || CNT_W < 1) begin : g_param_check
        $error("mux_n_1_stream: CH must be >= 2 and CNT_W >= 1");
    end

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic             in_xfer;
    logic             out_xfer;
    logic [DW-1:0]    grant_data;
    int               scan_idx;

    assign load_en  = !o_valid || i_ready;
    assign out_xfer = o_valid && i_ready;
    assign in_xfer  = load_en && grant_valid;

    // Grant selection: explicit select in fixed mode, first valid after rr_ptr otherwise
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        scan_idx    = 0;
        if (!i_mode) begin
            for (int k = 0; k < CH; k++) begin
                if (i_sel == SEL_W'(k) && i_valid[k]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(k);
                end
            end
        end else begin
            for (int off = 1; off <= CH; off++) begin
                scan_idx = (int'(rr_ptr) + off) % CH;
                if (!grant_valid && i_valid[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(scan_idx);
                end
            end
        end
    end

    // Ready goes only to the granted channel, and only when the output register can load
    always_comb begin
        o_ready    = '0;
        grant_data = i_data[int'(grant)*DW +: DW];
        for (int k = 0; k < CH; k++) begin
            o_ready[k] = in_xfer && (grant == SEL_W'(k));
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            rr_ptr  <= SEL_W'(CH - 1);
        end else if (in_xfer) begin
            o_valid <= 1'b1;
            o_data  <= grant_data;
            o_ch    <= grant;
            if (i_mode) begin
                rr_ptr <= grant;
            end
        end else if (out_xfer) begin
            o_valid <= 1'b0;
        end
    end

`ifdef MUX_N_1_STREAM_CNT_EN
    // Count accepted output words, wrapping at the counter width
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_xfer_cnt <= '0;
        end else if (out_xfer) begin
            o_xfer_cnt <= o_xfer_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb/tb_mux_n_1_stream.sv - randomized and directed bench for mux_n_1_stream
module tb_mux_n_1_stream;
    localparam int DW = 4, CH = 4, SEL_W = 3, CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH*DW-1:0] data;
    logic [CH-1:0]    valid;
    logic [CH-1:0]    ready_o;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [DW-1:0]    o_data;
    logic [SEL_W-1:0] o_ch;
    logic             o_valid;
    logic             rdy_in;
`ifdef MUX_N_1_STREAM_CNT_EN
    logic [CNT_W-1:0] xfer_cnt;
`endif

    mux_n_1_stream #(.DW(DW), .CH(CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready_o),
        .i_mode  (mode),
        .i_sel   (sel),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_valid (o_valid),
        .i_ready (rdy_in)
`ifdef MUX_N_1_STREAM_CNT_EN
        ,
        .o_xfer_cnt (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the word in the output register, its source and the last rr winner
    bit m_valid;
    int m_data, m_ch, m_last, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_ch    = 0;
        m_last  = CH - 1;
        m_cnt   = 0;
    endtask

    function automatic int model_grant();
        if (!mode) begin
            if (int'(sel) < CH) begin
                if (valid[sel[1:0]]) return int'(sel);
            end
            return -1;
        end
        for (int off = 1; off <= CH; off++) begin
            int c;
            c = (m_last + off) % CH;
            if (valid[c]) return c;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs driven: check outputs, advance the model, reach next negedge
    task automatic step();
        int g;
        bit can_load;
        logic [CH-1:0] exp_rdy;
        #1;
        can_load = !m_valid || rdy_in;
        g        = model_grant();
        exp_rdy  = '0;
        if (can_load && g >= 0) exp_rdy[g] = 1'b1;
        chk("o_ready", ready_o, exp_rdy);
        chk("o_valid", o_valid, m_valid);
        chk("o_data", o_data, m_data);
        chk("o_ch", o_ch, m_ch);
`ifdef MUX_N_1_STREAM_CNT_EN
        chk("o_xfer_cnt", xfer_cnt, m_cnt);
`endif
        if (m_valid && rdy_in) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (can_load && g >= 0) begin
            m_valid = 1;
            m_data  = int'(data[g*DW +: DW]);
            m_ch    = g;
            if (mode) m_last = g;
        end else if (m_valid && rdy_in) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_ch", o_ch, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        data   = '0;
        valid  = '0;
        mode   = 1'b0;
        sel    = '0;
        rdy_in = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // T1: fixed select of channel 2
        mode = 1'b0; sel = 3'd2; valid = 4'b0100; data = '0; data[2*DW +: DW] = 4'hA; rdy_in = 1'b1;
        #1 chk("t1_ready", ready_o, 4'b0100);
        step();
        chk("t1_valid", o_valid, 1);
        chk("t1_data", o_data, 4'hA);
        chk("t1_ch", o_ch, 2);

        // T2: round-robin with all channels valid
        do_reset();
        mode = 1'b1; valid = 4'b1111; data = 16'h3210; rdy_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_ch", o_ch, i % 4);
            chk("t2_data", o_data, i % 4);
        end

        // T3: stall holds the word; ch3 loads once ready returns
        do_reset();
        mode = 1'b0; sel = 3'd1; valid = 4'b0010; data = '0; data[1*DW +: DW] = 4'h5; rdy_in = 1'b1;
        step();
        rdy_in = 1'b0; sel = 3'd3; valid = 4'b1000; data[3*DW +: DW] = 4'h9;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_ready", ready_o, 4'b0000);
            step();
            chk("t3_data", o_data, 4'h5);
            chk("t3_ch", o_ch, 1);
        end
        rdy_in = 1'b1;
        step();
        chk("t3_load_data", o_data, 4'h9);
        chk("t3_load_ch", o_ch, 3);

        // T4: select without valid, and out-of-range select
        do_reset();
        mode = 1'b0; sel = 3'd3; valid = 4'b0001; rdy_in = 1'b1;
        step();
        chk("t4_sel3_valid", o_valid, 0);
        sel = 3'd5; valid = 4'b1111;
        #1 chk("t4_sel5_ready", ready_o, 4'b0000);
        step();
        chk("t4_sel5_valid", o_valid, 0);

        // T5: reset while a word is held; ch0 wins first afterwards
        do_reset();
        mode = 1'b1; valid = 4'b0100; data = 16'h7654; rdy_in = 1'b1;
        step();
        step();
        chk("t5_pre_ch", o_ch, 2);
        do_reset();
        valid = 4'b1111;
        step();
        chk("t5_first_ch", o_ch, 0);

`ifdef MUX_N_1_STREAM_CNT_EN
        // T6: 17 output transfers with a stall in the middle wrap a 4-bit counter to 1
        do_reset();
        mode = 1'b1; valid = 4'b1111; rdy_in = 1'b1;
        for (int i = 0; i < 9; i++) step();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rdy_in = 1'b1;
        for (int i = 0; i < 9; i++) step();
        rdy_in = 1'b0;
        #1 chk("t6_cnt", xfer_cnt, 1);
        step();
`endif

        // Randomized traffic with occasional mode/select changes and resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
            sel    = SEL_W'($urandom_range(0, 7));
            valid  = CH'($urandom);
            data   = (CH*DW)'($urandom);
            rdy_in = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
